// File: rtl/transmitter_axis.sv
// transmitter_axis
//   UART transmitter fed by an AXI4-Stream slave port. One word is accepted
//   per handshake and sent on `dout` as: start bit (0), WORD_WIDTH data bits
//   LSB first, stop bit (1). Each bit lasts CLOCK_FREQUENCY / BAUD_RATE clocks.
//
// Ports
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   din_axis_tdata   word to transmit
//   din_axis_tvalid  producer has a word
//   din_axis_tready  block can accept a word (registered)
//   dout             serial line, idle high (registered)
//   busy             frame in progress (registered)
//
// Handshake: a word transfers on a rising edge where tvalid && tready are both
// high. tready is high only in IDLE, so a producer that holds tvalid across a
// frame is accepted again only after the stop bit has fully elapsed.
module transmitter_axis #(
  parameter int unsigned CLOCK_FREQUENCY = 32'd100_000_000,
  parameter int unsigned BAUD_RATE       = 32'd115200,
  parameter int unsigned WORD_WIDTH      = 32'd8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_WIDTH-1:0] din_axis_tdata,
  input  logic                  din_axis_tvalid,
  output logic                  din_axis_tready,
  output logic                  dout,
  output logic                  busy
);

  // Must come out >= 2 for the chosen clock and baud rate.
  localparam int unsigned CYCLES_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int unsigned BIT_W          = $clog2(WORD_WIDTH + 2);

  localparam logic [31:0]      LAST_CYCLE    = 32'(CYCLES_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_DATA_IDX = BIT_W'(WORD_WIDTH);
  localparam logic [BIT_W-1:0] STOP_IDX      = BIT_W'(WORD_WIDTH + 1);

  typedef enum logic {
    IDLE      = 1'b0,
    SEND_BITS = 1'b1
  } state_t;

  state_t                state;
  logic [31:0]           cycle_cnt;
  logic [BIT_W-1:0]      bit_idx;
  logic [WORD_WIDTH-1:0] shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cycle_cnt       <= '0;
      bit_idx         <= '0;
      shift_q         <= '0;
      din_axis_tready <= 1'b0;
      dout            <= 1'b1;
      busy            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dout <= 1'b1;
          if (din_axis_tvalid && din_axis_tready) begin
            shift_q         <= din_axis_tdata;
            din_axis_tready <= 1'b0;
            busy            <= 1'b1;
            dout            <= 1'b0;  // start bit goes out on the handshake edge
            cycle_cnt       <= '0;
            bit_idx         <= '0;
            state           <= SEND_BITS;
          end else begin
            // Also the first edge after reset release.
            din_axis_tready <= 1'b1;
            busy            <= 1'b0;
          end
        end

        SEND_BITS: begin
          if (cycle_cnt == LAST_CYCLE) begin
            cycle_cnt <= '0;
            if (bit_idx == STOP_IDX) begin
              state           <= IDLE;
              din_axis_tready <= 1'b1;
              busy            <= 1'b0;
              dout            <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              // Indices 0..WORD_WIDTH-1 are followed by a data bit; the last
              // data bit is followed by the stop bit.
              if (bit_idx < LAST_DATA_IDX) begin
                dout    <= shift_q[0];
                shift_q <= shift_q >> 1;
              end else begin
                dout <= 1'b1;
              end
            end
          end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
